// File: rtl/cas_fsk_encoder_pkg.sv
// cas_pkg: shared types and constants for the cassette FSK encoder.
//   cas_cmd_e    : command codes carried on the command interface
//   cas_state_e  : engine states
//   FRAME_BITS   : bits per byte frame (start + 8 data + 2 stop)
//   CNT_W        : width of the pulse/silence counter
//   frame_bit()  : level of frame bit idx for a given data byte
package cas_pkg;

  typedef enum logic [1:0] {
    CAS_DATA = 2'd0,
    CAS_SHDR = 2'd1,
    CAS_LHDR = 2'd2,
    CAS_SIL  = 2'd3
  } cas_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BYTE,
    ST_SIL
  } cas_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned CNT_W      = 18;

  typedef logic [CNT_W-1:0] cnt_t;

  // Frame order on tape: start bit 0, D0..D7, then two stop bits of 1.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [10:0] frame;
    frame = {2'b11, data, 1'b0};
    if (idx < 4'(FRAME_BITS)) frame_bit = frame[idx];
    else                      frame_bit = 1'b1;
  endfunction

endpackage

// File: rtl/cas_fsk_encoder_if.sv
// Command interface between the CAS file parser and the FSK encoder.
//   cmd_valid : command present
//   cmd_type  : DATA / SHORT_HDR / LONG_HDR / SILENCE
//   cmd_data  : byte for DATA, unit count minus 1 for SILENCE
//   cmd_ready : encoder can take a command
// master = parser side, slave = encoder side.
interface cas_fsk_encoder_if;
  import cas_pkg::*;

  logic       cmd_valid;
  cas_cmd_e   cmd_type;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, cmd_type, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_type, cmd_data, output cmd_ready);
endinterface

// File: rtl/cas_fsk_encoder_half_timer.sv
// cas_half_timer: loadable down-counter timing one half-cycle of the tone.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (flush)
//   en           : tick enable (ce && play)
//   run          : engine active; no half ends while idle
//   load         : load load_val (next half length minus 1)
//   load_val     : half length minus 1
//   half_done    : high on the final tick of the current half
module cas_half_timer #(
  parameter int unsigned TW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          run,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          half_done
);

  typedef logic [TW-1:0] tick_t;

  tick_t tick_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (load) begin
      tick_cnt <= load_val;
    end else if (en && run && (tick_cnt != '0)) begin
      tick_cnt <= tick_cnt - tick_t'(1);
    end
  end

  assign half_done = en && run && (tick_cnt == '0);

endmodule

// File: rtl/cas_fsk_encoder.sv
// cas_fsk_encoder: turns cassette commands (header tone, data byte, silence)
// into the MSX 1200-baud FSK square wave for the tape audio input.
//   clk, reset_n : system clock, asynchronous active-low reset
//   ce           : tick enable; all waveform timing counts ce ticks
//   play         : 1 = run, 0 = freeze the engine and hold cas_out
//   flush        : synchronous abort of active and pending commands
//   cmd          : command interface (slave side), one-entry skid register
//   cas_out      : FSK output level
//   busy         : engine active or command pending
module cas_fsk_encoder
  import cas_pkg::*;
#(
  parameter int unsigned HALF_LO      = 2236,
  parameter int unsigned LONG_PULSES  = 16000,
  parameter int unsigned SHORT_PULSES = 4000,
  parameter int unsigned SIL_UNIT     = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                play,
  input  logic                flush,
  cas_fsk_encoder_if.slave    cmd,
  output logic                cas_out,
  output logic                busy
);

  localparam int unsigned HALF_HI = HALF_LO / 2;
  localparam int unsigned TW      = $clog2(HALF_LO);

  typedef logic [TW-1:0] tick_t;

  localparam tick_t LO_LOAD = tick_t'(HALF_LO - 1);
  localparam tick_t HI_LOAD = tick_t'(HALF_HI - 1);

  // Skid register
  logic       pend_v;
  cas_cmd_e   pend_type;
  logic [7:0] pend_data;

  // Engine state
  cas_state_e state, state_nxt;
  logic       cas_q, cas_nxt;
  logic [1:0] half_idx, half_nxt;
  logic [3:0] bit_idx, bit_nxt;
  cnt_t       cnt, cnt_nxt;
  logic [7:0] data_q, data_nxt;

  // Timer control
  logic  tick;
  logic  half_done;
  logic  t_load;
  tick_t t_val;

  logic start;
  logic finish;
  logic cur_bit;
  logic nxt_bit;

  assign tick = ce && play;

  cas_half_timer #(.TW(TW)) u_half_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .en        (tick),
    .run       (state != ST_IDLE),
    .load      (t_load),
    .load_val  (t_val),
    .half_done (half_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cas_q    <= 1'b0;
      half_idx <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      cas_q    <= cas_nxt;
      half_idx <= half_nxt;
      bit_idx  <= bit_nxt;
      cnt      <= cnt_nxt;
      data_q   <= data_nxt;
    end
  end

  // A command can only be taken while the slot is empty, and the engine only
  // consumes it while the slot is full, so accept and consume never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v    <= 1'b0;
      pend_type <= CAS_DATA;
      pend_data <= '0;
    end else if (flush) begin
      pend_v    <= 1'b0;
    end else if (start) begin
      pend_v    <= 1'b0;
    end else if (cmd.cmd_valid && !pend_v) begin
      pend_v    <= 1'b1;
      pend_type <= cmd.cmd_type;
      pend_data <= cmd.cmd_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cas_nxt   = cas_q;
    half_nxt  = half_idx;
    bit_nxt   = bit_idx;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    t_load    = 1'b0;
    t_val     = LO_LOAD;
    start     = 1'b0;
    finish    = 1'b0;
    cur_bit   = frame_bit(data_q, bit_idx);
    nxt_bit   = frame_bit(data_q, bit_idx + 4'd1);

    case (state)
      ST_IDLE: begin
        start = tick && pend_v;
      end

      // cnt holds remaining full cycles after the current one.
      ST_HDR: begin
        if (half_done) begin
          if (!half_idx[0]) begin
            half_nxt = 2'd1;
            cas_nxt  = 1'b0;
            t_load   = 1'b1;
            t_val    = HI_LOAD;
          end else if (cnt == '0) begin
            finish = 1'b1;
          end else begin
            cnt_nxt  = cnt - cnt_t'(1);
            half_nxt = 2'd0;
            cas_nxt  = 1'b1;
            t_load   = 1'b1;
            t_val    = HI_LOAD;
          end
        end
      end

      // A 0 bit is two long halves, a 1 bit four short halves; even halves
      // are high, odd halves low.
      ST_BYTE: begin
        if (half_done) begin
          if (half_idx != (cur_bit ? 2'd3 : 2'd1)) begin
            half_nxt = half_idx + 2'd1;
            cas_nxt  = half_idx[0];
            t_load   = 1'b1;
            t_val    = cur_bit ? HI_LOAD : LO_LOAD;
          end else if (bit_idx == 4'(FRAME_BITS - 1)) begin
            finish = 1'b1;
          end else begin
            bit_nxt  = bit_idx + 4'd1;
            half_nxt = 2'd0;
            cas_nxt  = 1'b1;
            t_load   = 1'b1;
            t_val    = nxt_bit ? HI_LOAD : LO_LOAD;
          end
        end
      end

      // cnt holds remaining long halves of silence after the current one.
      ST_SIL: begin
        if (half_done) begin
          if (cnt == '0) begin
            finish = 1'b1;
          end else begin
            cnt_nxt = cnt - cnt_t'(1);
            t_load  = 1'b1;
            t_val   = LO_LOAD;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Back-to-back: a pending command starts on the very tick the last half
    // ends, so there is no idle tick between commands.
    if (finish) begin
      if (pend_v) begin
        start = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
        cas_nxt   = 1'b0;
        half_nxt  = '0;
        bit_nxt   = '0;
        cnt_nxt   = '0;
      end
    end

    if (start) begin
      half_nxt = '0;
      bit_nxt  = '0;
      data_nxt = pend_data;
      t_load   = 1'b1;
      case (pend_type)
        CAS_DATA: begin
          state_nxt = ST_BYTE;
          cas_nxt   = 1'b1;
          cnt_nxt   = '0;
          t_val     = LO_LOAD;
        end
        CAS_SHDR: begin
          state_nxt = ST_HDR;
          cas_nxt   = 1'b1;
          cnt_nxt   = cnt_t'(SHORT_PULSES - 1);
          t_val     = HI_LOAD;
        end
        CAS_LHDR: begin
          state_nxt = ST_HDR;
          cas_nxt   = 1'b1;
          cnt_nxt   = cnt_t'(LONG_PULSES - 1);
          t_val     = HI_LOAD;
        end
        default: begin
          state_nxt = ST_SIL;
          cas_nxt   = 1'b0;
          cnt_nxt   = cnt_t'((32'(pend_data) + 32'd1) * SIL_UNIT * 32'd2 - 32'd1);
          t_val     = LO_LOAD;
        end
      endcase
    end

    if (flush) begin
      state_nxt = ST_IDLE;
      cas_nxt   = 1'b0;
      half_nxt  = '0;
      bit_nxt   = '0;
      cnt_nxt   = '0;
      data_nxt  = '0;
      t_load    = 1'b0;
      t_val     = LO_LOAD;
      start     = 1'b0;
    end
  end

  assign cmd.cmd_ready = !pend_v;
  assign busy          = (state != ST_IDLE) || pend_v;
  assign cas_out       = cas_q;

endmodule

// File: tb/tb_cas_fsk_encoder.sv
module tb_cas_fsk_encoder;
  import cas_pkg::*;

  localparam int T_LO    = 8;
  localparam int T_HI    = T_LO / 2;
  localparam int T_LONG  = 8;
  localparam int T_SHORT = 2;
  localparam int T_SIL   = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic ce      = 1'b1;
  logic play    = 1'b1;
  logic flush   = 1'b0;
  logic cas_out;
  logic busy;

  cas_fsk_encoder_if cif();

  cas_fsk_encoder #(
    .HALF_LO      (T_LO),
    .LONG_PULSES  (T_LONG),
    .SHORT_PULSES (T_SHORT),
    .SIL_UNIT     (T_SIL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .play    (play),
    .flush   (flush),
    .cmd     (cif),
    .cas_out (cas_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  typedef struct {
    int t;
    int d;
    int len;
    int rises;
    int highs;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cycle(input int half);
    for (int i = 0; i < half; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < half; i++) exp_q.push_back(1'b0);
  endtask

  // Reference waveform, one entry per ce tick.
  task automatic model_push(input int t, input int d);
    logic [10:0] frame;
    logic [7:0]  db;
    db    = 8'(d);
    frame = {2'b11, db, 1'b0};
    case (t)
      0: begin
        for (int b = 0; b < 11; b++) begin
          if (frame[b]) begin
            push_cycle(T_HI);
            push_cycle(T_HI);
          end else begin
            push_cycle(T_LO);
          end
        end
      end
      1: for (int c = 0; c < T_SHORT; c++) push_cycle(T_HI);
      2: for (int c = 0; c < T_LONG; c++) push_cycle(T_HI);
      default: for (int i = 0; i < (d + 1) * T_SIL * 2 * T_LO; i++) exp_q.push_back(1'b0);
    endcase
  endtask

  task automatic send(input int t, input int d);
    bit r;
    bit ok;
    logic [1:0] tt;
    ok = 1'b0;
    tt = t[1:0];
    cif.cmd_valid = 1'b1;
    cif.cmd_type  = cas_cmd_e'(tt);
    cif.cmd_data  = 8'(d);
    for (int n = 0; n < 3000; n++) begin
      r = cif.cmd_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    cif.cmd_valid = 1'b0;
    chk("send_accepted", int'(ok), 1);
  endtask

  // Starts sampling at the next negedge; expects exp_q tick by tick.
  task automatic check_wave(input string name, input int pause_at, input int pause_len);
    int first_bad;
    int busy_bad;
    int hold_bad;
    first_bad = -1;
    busy_bad  = -1;
    hold_bad  = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == pause_at && i > 0) begin
        play = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          @(negedge clk);
          if ((cas_out !== exp_q[i-1] || busy !== 1'b1) && hold_bad < 0) hold_bad = p;
        end
        play = 1'b1;
      end
      @(negedge clk);
      if (cas_out !== exp_q[i] && first_bad < 0) first_bad = i;
      if (busy !== 1'b1 && busy_bad < 0) busy_bad = i;
    end
    chk({name, "_first_bad_tick"}, first_bad, -1);
    chk({name, "_busy_drop_tick"}, busy_bad, -1);
    if (pause_len > 0) chk({name, "_pause_hold_bad"}, hold_bad, -1);
    @(negedge clk);
    chk({name, "_end_cas"}, int'(cas_out), 0);
    chk({name, "_end_busy"}, int'(busy), 0);
    chk({name, "_end_ready"}, int'(cif.cmd_ready), 1);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, rises, highs, done;
    logic prev;
    int ct[8];
    int cd[8];
    int bad;

    vt[0] = '{0, 'hA5, 176, 17, 88};
    vt[1] = '{0, 'h00, 176, 13, 88};
    vt[2] = '{0, 'hFF, 176, 21, 88};
    vt[3] = '{1, 0,     16,  2,  8};
    vt[4] = '{2, 0,     64,  8, 32};
    vt[5] = '{3, 2,     48,  0,  0};
    vt[6] = '{3, 0,     16,  0,  0};

    cif.cmd_valid = 1'b0;
    cif.cmd_type  = CAS_DATA;
    cif.cmd_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_cas", int'(cas_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(cif.cmd_ready), 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: length, rising edges and high ticks per command
    foreach (vt[k]) begin
      send(vt[k].t, vt[k].d);
      @(posedge clk);
      len = 0; rises = 0; highs = 0; done = 0; prev = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        if (!busy) begin
          done = 1;
          break;
        end
        len++;
        if (cas_out) highs++;
        if (cas_out && !prev) rises++;
        prev = cas_out;
      end
      chk($sformatf("tbl%0d_done", k), done, 1);
      chk($sformatf("tbl%0d_len", k), len, vt[k].len);
      chk($sformatf("tbl%0d_rises", k), rises, vt[k].rises);
      chk($sformatf("tbl%0d_highs", k), highs, vt[k].highs);
      chk($sformatf("tbl%0d_idle_cas", k), int'(cas_out), 0);
      @(negedge clk);
    end

    // DATA 0xA5 waveform
    send(0, 'hA5);
    @(posedge clk);
    model_push(0, 'hA5);
    check_wave("data_a5", -1, 0);

    // LONG_HDR with DATA 0x00 queued behind it: gap-free hand-over
    send(2, 0);
    model_push(2, 0);
    model_push(0, 'h00);
    fork
      begin
        @(posedge clk);
        check_wave("hdr_then_data", -1, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        send(0, 'h00);
        @(negedge clk);
        chk("held_cmd_ready", int'(cif.cmd_ready), 0);
        chk("held_busy", int'(busy), 1);
      end
    join

    // SILENCE of 3 units
    send(3, 2);
    @(posedge clk);
    model_push(3, 2);
    check_wave("sil_2", -1, 0);

    // Pause in the middle of bit 3 of DATA 0xFF
    send(0, 'hFF);
    @(posedge clk);
    model_push(0, 'hFF);
    check_wave("pause_ff", 3 * 2 * T_LO + 6, 20);

    // Flush mid-byte with a command pending; the concurrent valid is dropped
    send(0, 'h5A);
    @(posedge clk);
    send(0, 'h33);
    repeat (30) @(negedge clk);
    chk("pre_flush_busy", int'(busy), 1);
    chk("pre_flush_ready", int'(cif.cmd_ready), 0);
    flush = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_type  = CAS_SHDR;
    @(negedge clk);
    chk("flush_cas", int'(cas_out), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_ready", int'(cif.cmd_ready), 1);
    flush = 1'b0;
    cif.cmd_valid = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (cas_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("post_flush_activity", bad, 0);

    // Flush while idle: a valid on the flush cycle must not be taken
    flush = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_type  = CAS_LHDR;
    @(negedge clk);
    flush = 1'b0;
    cif.cmd_valid = 1'b0;
    chk("idle_flush_busy", int'(busy), 0);
    chk("idle_flush_ready", int'(cif.cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk("idle_flush_no_start", int'(busy), 0);

    // Asynchronous reset mid-header, then DATA 0x01
    send(2, 0);
    repeat (10) @(posedge clk);
    #3;
    chk("pre_reset_cas", int'(cas_out), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_cas", int'(cas_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_ready", int'(cif.cmd_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(0, 'h01);
    @(posedge clk);
    model_push(0, 'h01);
    check_wave("after_reset_01", -1, 0);

    // Random back-to-back command stream with a random pause
    for (int k = 0; k < 8; k++) begin
      ct[k] = int'($urandom_range(0, 3));
      cd[k] = (ct[k] == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      model_push(ct[k], cd[k]);
    end
    send(ct[0], cd[0]);
    fork
      begin
        @(posedge clk);
        check_wave("random_stream", int'($urandom_range(1, 100)), int'($urandom_range(1, 15)));
      end
      begin
        for (int k = 1; k < 8; k++) send(ct[k], cd[k]);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cas_fsk_encoder.md
Name: cas_fsk_encoder

Overview:
Converts a stream of cassette commands (header tone, data byte, silence) into the MSX 1200-baud FSK square wave that drives the core's tape audio input. It sits between the CAS file parser, which reads bytes from the DDRAM buffer, and the cas_audio_in selection in the top level. A one-entry command skid register lets consecutive commands play back with no gap between them.

Parameters:
HALF_LO, 2236, ce ticks per half-cycle of the 1200 Hz tone (a "0" bit is one full cycle); the derived constant HALF_HI = HALF_LO/2 sets the 2400 Hz half-cycle
LONG_PULSES, 16000, number of 2400 Hz cycles in a long header
SHORT_PULSES, 4000, number of 2400 Hz cycles in a short header
SIL_UNIT, 64, bit-times per silence unit

Ports:
clk  in  1  system clock (42.95 MHz)
reset_n  in  1  asynchronous active-low reset
ce  in  1  tick enable (ce_5m3 in the system); all timing counts ce ticks
play  in  1  1 = run; 0 = freeze every counter and hold cas_out
flush  in  1  synchronous abort: drop the active and pending commands, go to IDLE
cmd_valid  in  1  command present
cmd_type  in  2  0=DATA, 1=SHORT_HDR, 2=LONG_HDR, 3=SILENCE
cmd_data  in  8  byte for DATA; unit count minus 1 for SILENCE; ignored otherwise
cmd_ready  out  1  skid register empty
cas_out  out  1  FSK output level
busy  out  1  engine active or a command pending

Behaviour:
- Reset values: cas_out=0, cmd_ready=1, busy=0, state=IDLE, skid register empty.
- Handshake: a command is accepted when cmd_valid && cmd_ready (a clk edge, independent of ce). It goes into the skid register; cmd_ready=!pend_v.
- Engine states: IDLE, HDR, BYTE, SIL. In IDLE with pend_v set, the next ce&&play tick loads the command, clears pend_v, and begins the first half-cycle.
- Cycle shape: every tone cycle is a high half followed by a low half. A half of length L holds cas_out for L ce ticks, counted by tick_cnt from L-1 down to 0.
- BYTE: an 11-bit frame sent as start bit 0, data bits D0..D7 (LSB first), then two stop bits of 1.
  - Bit 0 = one HALF_LO cycle (2 halves).
  - Bit 1 = two HALF_HI cycles (4 halves).
  - Every bit therefore lasts 2*HALF_LO ticks.
- HDR: SHORT_PULSES or LONG_PULSES HALF_HI cycles.
- SIL: cas_out=0 for (cmd_data+1)*SIL_UNIT*2*HALF_LO ticks.
- Completion: on the tick where the last half ends:
  - if pend_v is set, the pending command loads on that same tick, so the waveform is gap-free and the new first half starts high (cas_out=0 for SIL);
  - otherwise the engine goes to IDLE with cas_out=0.
- busy = (state!=IDLE) || pend_v.
- play=0: counters, state and cas_out hold. Accepting into the skid register still works.
- flush: highest priority. Next clk gives state=IDLE, pend_v=0, cas_out=0, all counters cleared. A cmd_valid on the same cycle as flush is dropped.
- Counter widths:
  - tick_cnt: clog2(HALF_LO) bits
  - half index: 2 bits
  - bit index: 4 bits
  - pulse/silence counter: 18 bits (covers 256*64*2 halves... sized as max(LONG_PULSES, 256*SIL_UNIT))
- An asynchronous reset mid-command returns to the reset values immediately.

Decomposition:
- Package cas_pkg: the cmd_type enum (CAS_DATA, CAS_SHDR, CAS_LHDR, CAS_SIL), the state enum, and the frame length constant FRAME_BITS=11.
- Sub-module cas_half_timer: loadable down-counter with ce/play gating that pulses half_done on the final tick. It is instantiated once.

Test Plan (bench parameters: HALF_LO=8, LONG_PULSES=8, SHORT_PULSES=2, SIL_UNIT=1, ce=1 every clk, play=1):
- DATA 0xA5 → bit pattern 0,1,0,1,0,0,1,0,1,1,1. Total 176 ticks. Zero bits show 8 high/8 low; one bits show 4/4/4/4. Ends with cas_out=0, busy=0.
- LONG_HDR, then DATA 0x00 accepted while the header plays → 64 ticks of 4/4 cycles, then the start bit begins on the very next tick with no gap. cmd_ready drops to 0 while the command is held.
- SILENCE cmd_data=2 → cas_out=0 for 48 ticks, busy=1 throughout, busy=0 on tick 49.
- play=0 for 20 clks in the middle of bit 3 of DATA 0xFF → cas_out frozen during the pause. The total waveform is 176 ticks plus 20 extra clks, and the bit sequence is unchanged.
- flush asserted in the middle of a byte with a command pending → next clk gives cas_out=0, busy=0, cmd_ready=1, and no further edges appear.
- reset_n low mid-header → outputs return to their reset values asynchronously; after release, DATA 0x01 plays correctly.
